// File: rtl/fm_result_dma_writer.sv
`default_nettype none
// ============================================================================
//  Module      : fm_result_dma_writer
//  Description : Writes frequency-meter results into a circular buffer in the
//                measurement RAM through its raw port. Tracks the fill level and
//                overflow drops, and raises an interrupt for the CPU.
//  Revision    : 1.0 - initial release
// ============================================================================
module fm_result_dma_writer #(
    parameter int ADDR_WIDTH = 11,
    parameter int BASE_WORD  = 0,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [31:0]           smp_dat_i,
    input  logic                  smp_valid_i,
    output logic                  smp_ready_o,
    input  logic                  enable_i,
    input  logic                  clear_i,
    input  logic [DEPTH_LOG2:0]   rd_ptr_i,
    input  logic [DEPTH_LOG2:0]   irq_level_i,
    output logic [ADDR_WIDTH-1:0] rawp_adr_o,
    output logic [31:0]           rawp_dat_o,
    output logic                  rawp_we_o,
    input  logic                  rawp_stall_i,
    output logic [DEPTH_LOG2:0]   wr_ptr_o,
    output logic [DEPTH_LOG2:0]   level_o,
    output logic [15:0]           ovf_cnt_o,
    output logic                  error_o,
    output logic                  irq_o
);

    localparam int c_PTR_W  = DEPTH_LOG2 + 1;
    localparam int c_WORD_W = ADDR_WIDTH - 2;

    localparam logic [c_PTR_W-1:0] c_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_WRITE = 2'd1;
    localparam logic [1:0] c_ST_CHECK = 2'd2;
    localparam logic [1:0] c_ST_ERROR = 2'd3;

    logic [1:0]            r_state;
    logic [c_PTR_W-1:0]    r_wr_ptr;
    logic [15:0]           r_ovf_cnt;
    logic                  r_error;
    logic                  r_irq;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_adr;
    logic [31:0]           r_dat;

    logic [c_PTR_W-1:0]    w_level;
    logic                  w_full;
    logic                  w_handshake;
    logic [c_WORD_W-1:0]   w_word;

    assign w_level     = r_wr_ptr - rd_ptr_i;
    assign w_full      = (w_level == c_FULL);
    // Ready is held low while reset is asserted so every output reads zero.
    assign smp_ready_o = (r_state == c_ST_IDLE) & enable_i & ~rst_i;
    assign w_handshake = smp_valid_i & smp_ready_o;
    assign w_word      = c_WORD_W'(BASE_WORD) + c_WORD_W'(r_wr_ptr[DEPTH_LOG2-1:0]);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= c_ST_IDLE;
            r_wr_ptr  <= '0;
            r_ovf_cnt <= '0;
            r_error   <= 1'b0;
            r_irq     <= 1'b0;
            r_we      <= 1'b0;
            r_adr     <= '0;
            r_dat     <= '0;
        end else begin
            r_irq <= r_error | ((irq_level_i != '0) && (w_level >= irq_level_i));
            if (clear_i) begin
                r_state   <= c_ST_IDLE;
                r_wr_ptr  <= '0;
                r_ovf_cnt <= '0;
                r_error   <= 1'b0;
                r_we      <= 1'b0;
            end else begin
                case (r_state)
                    c_ST_IDLE: begin
                        if (w_handshake) begin
                            if (w_full) begin
                                if (r_ovf_cnt != 16'hFFFF) begin
                                    r_ovf_cnt <= r_ovf_cnt + 16'd1;
                                end
                            end else begin
                                r_dat   <= smp_dat_i;
                                r_adr   <= {w_word, 2'b00};
                                r_we    <= 1'b1;
                                r_state <= c_ST_WRITE;
                            end
                        end
                    end
                    c_ST_WRITE: begin
                        r_we    <= 1'b0;
                        r_state <= c_ST_CHECK;
                    end
                    c_ST_CHECK: begin
                        // The RAM's stall flag now reflects the address just written.
                        if (rawp_stall_i) begin
                            r_error <= 1'b1;
                            r_state <= c_ST_ERROR;
                        end else begin
                            r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
                            r_state  <= c_ST_IDLE;
                        end
                    end
                    c_ST_ERROR: begin
                        r_state <= c_ST_ERROR;
                    end
                    default: begin
                        r_state <= c_ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign rawp_adr_o = r_adr;
    assign rawp_dat_o = r_dat;
    assign rawp_we_o  = r_we;
    assign wr_ptr_o   = r_wr_ptr;
    assign level_o    = w_level;
    assign ovf_cnt_o  = r_ovf_cnt;
    assign error_o    = r_error;
    assign irq_o      = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_fm_result_dma_writer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fm_result_dma_writer
//  Description : Self-checking bench: transaction-level model plus RAM model,
//                directed scenarios and randomized traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_fm_result_dma_writer;

    localparam int AW   = 11;
    localparam int D    = 4;
    localparam int PW   = D + 1;
    localparam int BASE = 0;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   smp_dat;
    logic          smp_valid;
    logic          smp_ready;
    logic          enable;
    logic          clear;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] irq_level;
    logic [AW-1:0] rawp_adr;
    logic [31:0]   rawp_dat;
    logic          rawp_we;
    logic          rawp_stall;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] level;
    logic [15:0]   ovf_cnt;
    logic          error;
    logic          irq;

    always #5 clk = ~clk;

    fm_result_dma_writer #(.ADDR_WIDTH(AW), .BASE_WORD(BASE), .DEPTH_LOG2(D)) dut (
        .clk_i(clk), .rst_i(rst), .smp_dat_i(smp_dat), .smp_valid_i(smp_valid),
        .smp_ready_o(smp_ready), .enable_i(enable), .clear_i(clear), .rd_ptr_i(rd_ptr),
        .irq_level_i(irq_level), .rawp_adr_o(rawp_adr), .rawp_dat_o(rawp_dat),
        .rawp_we_o(rawp_we), .rawp_stall_i(rawp_stall), .wr_ptr_o(wr_ptr),
        .level_o(level), .ovf_cnt_o(ovf_cnt), .error_o(error), .irq_o(irq)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // RAM port B: writes in-range words, flags out-of-range writes one cycle later
    logic [31:0]   ram [0:511];
    int            ram_words = 512;
    logic [AW-1:0] we_log [$];
    always @(posedge clk) begin
        rawp_stall <= 1'b0;
        if (rawp_we === 1'b1) begin
            we_log.push_back(rawp_adr);
            if (int'(rawp_adr >> 2) < ram_words) ram[rawp_adr[AW-1:2]] <= rawp_dat;
            else rawp_stall <= 1'b1;
        end
    end

    // Transaction model: each accepted sample occupies a 2-cycle busy window
    int            m_wr, m_ovf, m_busy;
    bit            m_err, m_irq, m_oob;
    logic [AW-1:0] m_adr;
    logic [31:0]   m_dat;
    logic [31:0]   exp_mem [0:511];

    function automatic int lvl_of(input int wr, input int rd);
        return (wr - rd) & ((1 << PW) - 1);
    endfunction

    always @(posedge clk or posedge rst) begin : model
        int lv;
        int word;
        bit rdy;
        if (rst) begin
            m_wr <= 0; m_ovf <= 0; m_busy <= 0; m_err <= 0; m_irq <= 0;
            m_oob <= 0; m_adr <= '0; m_dat <= '0;
        end else begin
            lv  = lvl_of(m_wr, int'(rd_ptr));
            rdy = enable && (m_busy == 0) && !m_err;
            m_irq <= m_err || ((irq_level != 0) && (lv >= int'(irq_level)));
            if (m_busy == 2 && !m_oob) exp_mem[m_adr >> 2] <= m_dat;
            if (clear) begin
                m_wr <= 0; m_ovf <= 0; m_err <= 0; m_busy <= 0;
            end else if (m_busy == 2) begin
                m_busy <= 1;
            end else if (m_busy == 1) begin
                m_busy <= 0;
                if (m_oob) m_err <= 1;
                else m_wr <= (m_wr + 1) % (1 << PW);
            end else if (rdy && smp_valid) begin
                if (lv == (1 << D)) begin
                    m_ovf <= (m_ovf == 65535) ? m_ovf : m_ovf + 1;
                end else begin
                    word = BASE + (m_wr % (1 << D));
                    m_busy <= 2;
                    m_adr  <= AW'(word * 4);
                    m_dat  <= smp_dat;
                    m_oob  <= (word >= ram_words);
                end
            end
        end
    end

    always @(negedge clk) begin : compare
        bit exp_rdy;
        exp_rdy = enable && !rst && (m_busy == 0) && !m_err;
        chk("ready", smp_ready, exp_rdy);
        chk("we", rawp_we, m_busy == 2);
        if (m_busy != 0) begin
            chk("adr", rawp_adr, m_adr);
            chk("dat", rawp_dat, m_dat);
        end
        chk("wr_ptr", wr_ptr, m_wr);
        chk("level", level, lvl_of(m_wr, int'(rd_ptr)));
        chk("ovf", ovf_cnt, m_ovf);
        chk("error", error, m_err);
        chk("irq", irq, m_irq);
    end

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    task automatic settle(input int n);
        repeat (n) tick();
    endtask

    task automatic push(input logic [31:0] d);
        bit ok;
        bit r;
        ok = 0;
        smp_dat   = d;
        smp_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            r = smp_ready;
            tick();
            if (r) begin
                ok = 1;
                break;
            end
        end
        smp_valid = 1'b0;
        if (!ok) chk("push_timeout", 0, 1);
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    initial begin
        int n;
        rst = 1'b1; smp_dat = '0; smp_valid = 1'b0; enable = 1'b1; clear = 1'b0;
        rd_ptr = '0; irq_level = '0;
        repeat (3) @(negedge clk);
        #2;
        chk("rst_ready", smp_ready, 0);
        chk("rst_adr", rawp_adr, 0);
        chk("rst_we", rawp_we, 0);
        chk("rst_wr_ptr", wr_ptr, 0);
        chk("rst_irq", irq, 0);
        rst = 1'b0;
        tick();

        // Two pushes land at byte addresses 0 and 4
        push(32'hA5A5_0001);
        push(32'hA5A5_0002);
        settle(4);
        chk("first_we_adr", we_log[0], 11'h000);
        chk("second_we_adr", we_log[1], 11'h004);
        chk("wr_ptr_2", wr_ptr, 2);
        chk("ram0", ram[0], 32'hA5A5_0001);
        chk("ram1", ram[1], 32'hA5A5_0002);

        // Fill the ring, then overflow by one
        pulse_clear();
        rd_ptr = '0;
        for (int i = 0; i < 16; i++) push(32'h1000_0000 + i);
        settle(4);
        n = we_log.size();
        push(32'hDEAD_0017);
        settle(4);
        chk("no_17th_we", we_log.size(), n);
        chk("full_level", level, 16);
        chk("ovf_1", ovf_cnt, 1);

        // Wrap back to ring entry 0
        rd_ptr = 5'd16;
        push(32'h0000_BEEF);
        settle(4);
        chk("wrap_adr", we_log[$], 11'h000);
        chk("wrap_wr_ptr", wr_ptr, 17);
        chk("wrap_level", level, 1);

        // Level interrupt at threshold 4
        pulse_clear();
        rd_ptr = '0;
        irq_level = 5'd4;
        for (int i = 0; i < 3; i++) push(32'h2000_0000 + i);
        settle(4);
        chk("irq_below", irq, 0);
        push(32'h2000_0003);
        settle(2);
        chk("irq_wr4", wr_ptr, 4);
        chk("irq_lag", irq, 0);
        tick();
        chk("irq_set", irq, 1);
        rd_ptr = 5'd4;
        tick();
        chk("irq_drain", irq, 0);
        irq_level = '0;

        // Out-of-range write latches an error
        pulse_clear();
        rd_ptr = '0;
        ram_words = 2;
        for (int i = 0; i < 3; i++) push(32'h3000_0000 + i);
        settle(4);
        chk("err_set", error, 1);
        chk("err_wr_ptr", wr_ptr, 2);
        chk("err_irq", irq, 1);
        smp_valid = 1'b1;
        n = we_log.size();
        settle(3);
        chk("err_ready", smp_ready, 0);
        chk("err_no_we", we_log.size(), n);
        smp_valid = 1'b0;
        pulse_clear();
        chk("clr_err", error, 0);
        chk("clr_wr_ptr", wr_ptr, 0);
        chk("clr_ready", smp_ready, 1);
        ram_words = 512;
        settle(2);

        // Clear while the write strobe is high
        push(32'h4000_0000);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clrw_we", rawp_we, 0);
        chk("clrw_wr_ptr", wr_ptr, 0);
        chk("clrw_ready", smp_ready, 1);
        settle(2);

        // Asynchronous reset during CHECK
        push(32'h5000_0000);
        push(32'h5000_0001);
        settle(4);
        push(32'h5000_0002);
        tick();
        rst = 1'b1;
        #1;
        chk("arst_we", rawp_we, 0);
        chk("arst_adr", rawp_adr, 0);
        chk("arst_dat", rawp_dat, 0);
        chk("arst_wr_ptr", wr_ptr, 0);
        chk("arst_ready", smp_ready, 0);
        tick();
        rst = 1'b0;
        tick();

        // Randomized traffic, then a phase with a tiny RAM to provoke errors
        for (int ph = 0; ph < 2; ph++) begin
            ram_words = (ph == 0) ? 512 : 12;
            for (int c = 0; c < 1200; c++) begin
                smp_valid = ($urandom % 3) != 0;
                smp_dat   = $urandom;
                enable    = ($urandom % 16) != 0;
                clear     = ($urandom % ((ph == 0) ? 200 : 60)) == 0;
                if ($urandom % 8 == 0) rd_ptr = PW'((m_wr - int'($urandom_range(0, 16))) & 31);
                if (c % 100 == 0) irq_level = PW'($urandom_range(0, 16));
                tick();
            end
            smp_valid = 1'b0;
            clear = 1'b0;
            settle(4);
        end

        for (int i = 0; i < 32; i++) chk("ram_readback", ram[i], exp_mem[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fm_result_dma_writer.md
# fm_result_dma_writer

Producer-side stage for the dual-port measurement RAM: accepts 32-bit frequency-meter results on a valid/ready stream and writes them through the RAM's raw port (port B) into a circular buffer of 2^DEPTH_LOG2 words. Tracks the write pointer against a software-supplied read pointer, counts dropped samples on overflow, detects out-of-range writes via the RAM's stall flag, and raises a level interrupt for the CPU, which drains the buffer over Wishbone (port A).

## Interface
- ADDR_WIDTH, 11, byte-address width of the RAM raw port; must equal the RAM's WB_ADDR_WIDTH.
- BASE_WORD, 0, word index of the first ring entry.
- DEPTH_LOG2, 4, log2 of ring depth in 32-bit words; BASE_WORD + 2^DEPTH_LOG2 must not exceed RAM word count.

- clk_i  in  1  single clock, also drives RAM rawp_clk.
- rst_i  in  1  asynchronous, active-high reset.
- smp_dat_i  in  32  measurement result.
- smp_valid_i  in  1  result present.
- smp_ready_o  out  1  result accepted when valid & ready at clock edge.
- enable_i  in  1  capture enable.
- clear_i  in  1  synchronous clear of pointer, counters, error.
- rd_ptr_i  in  DEPTH_LOG2+1  software read pointer (entries consumed, wrapping).
- irq_level_i  in  DEPTH_LOG2+1  fill threshold; 0 disables level IRQ.
- rawp_adr_o  out  ADDR_WIDTH  byte address to RAM, bits [1:0] always 0.
- rawp_dat_o  out  32  write data to RAM.
- rawp_we_o  out  1  write strobe to RAM.
- rawp_stall_i  in  1  RAM's registered incorrect-address flag.
- wr_ptr_o  out  DEPTH_LOG2+1  write pointer (entries written, wrapping).
- level_o  out  DEPTH_LOG2+1  wr_ptr_o − rd_ptr_i, modulo 2^(DEPTH_LOG2+1).
- ovf_cnt_o  out  16  dropped-sample count, saturating at 16'hFFFF.
- error_o  out  1  sticky: RAM flagged a write address.
- irq_o  out  1  registered interrupt.

## Operation
- States: IDLE, WRITE, CHECK, ERROR. Reset → IDLE; all outputs 0, including smp_ready_o, rawp_*_o, wr_ptr_o, ovf_cnt_o, error_o, irq_o.
- IDLE: smp_ready_o = enable_i. On handshake: if level_o == 2^DEPTH_LOG2 (full), drop sample, ovf_cnt_o += 1 (saturating), stay IDLE; else latch data into rawp_dat_o, rawp_adr_o = (BASE_WORD + wr_ptr_o[DEPTH_LOG2-1:0]) << 2, go WRITE.
- WRITE: rawp_we_o = 1 for exactly this cycle; smp_ready_o = 0; → CHECK.
- CHECK: rawp_we_o = 0; sample rawp_stall_i (reflects the WRITE address). 1 → error_o = 1, ERROR, pointer unchanged. 0 → wr_ptr_o += 1 (wraps at 2^(DEPTH_LOG2+1)), → IDLE.
- ERROR: smp_ready_o = 0, no writes; exit only via clear_i or rst_i.
- clear_i (highest priority after reset, any state): next cycle wr_ptr_o = 0, ovf_cnt_o = 0, error_o = 0, rawp_we_o = 0, state IDLE. A write presented in WRITE in the same cycle still commits in RAM; pointer not advanced.
- enable_i deassert mid-write: current write completes normally; no further acceptance.
- irq_o = error_o | (irq_level_i != 0 & level_o >= irq_level_i), registered.
- rd_ptr_i ahead of wr_ptr_o (software error): level_o computed modulo, no special handling.

## Timing
- Accept → rawp_we_o high: 1 cycle (edge N accept, we high cycle N+1).
- Accept → wr_ptr_o update: 3 edges; next ready in cycle N+3. Sustained throughput 1 sample / 3 cycles.
- rawp_adr_o, rawp_dat_o stable from WRITE through CHECK.
- irq_o lags level/error change by 1 cycle.
- Asynchronous reset mid-WRITE: rawp_we_o drops immediately; RAM write at that edge is undefined and not tracked.

## Test plan
- Reset, enable=1, push 0xA5A5_0001, 0xA5A5_0002 → we pulses at byte addresses 0x000, 0x004 (BASE_WORD=0); wr_ptr_o = 2; RAM readback matches.
- Push 17 samples with rd_ptr_i = 0 → first 16 written, 17th accepted but dropped; level_o = 16, ovf_cnt_o = 1, no 17th we pulse.
- rd_ptr_i = 16 after fill, push 1 sample → written at address 0x000 (wrap), wr_ptr_o = 17, level_o = 1.
- irq_level_i = 4: after 3 writes irq_o = 0; after 4th write irq_o = 1 one cycle after wr_ptr_o update; set rd_ptr_i = 4 → irq_o = 0 next cycle.
- BASE_WORD beyond RAM size (rawp_stall_i = 1 in CHECK) → error_o = 1, irq_o = 1, smp_ready_o = 0 with valid held; pulse clear_i → error_o = 0, wr_ptr_o = 0, ready returns.
- Assert clear_i during WRITE → rawp_we_o 0 next cycle, wr_ptr_o = 0, state IDLE; assert rst_i mid-CHECK → all outputs 0 immediately.
